// File: rtl/demux_1x2_tdm.sv
// Time-division demultiplexer: one input stream steered to two registered
// output channels, with ch0->ch1 ordering check and completed-frame counter.
//
// state | meaning
// ------+--------------------------------------------
// EXP0  | next accepted word should target channel 0
// EXP1  | next accepted word should target channel 1
module demux_1x2_tdm #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic             seq_err,
    output logic [CNT_W-1:0] frame_cnt
);

    typedef enum logic {
        EXP0 = 1'b0,
        EXP1 = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic   in_xfer;
    logic   ch0_load;
    logic   ch1_load;
    logic   seq_err_next;
    logic   frame_inc;

    // Backpressure looks only at the channel the current word is headed for.
    assign in_ready = in_sel ? (!out1_valid || out1_ready) : (!out0_valid || out0_ready);
    assign in_xfer  = in_valid && in_ready;
    assign ch0_load = in_xfer && !in_sel;
    assign ch1_load = in_xfer && in_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
            out1_valid <= 1'b0;
            out1_data  <= '0;
        end else begin
            if (ch0_load) begin
                out0_data  <= in_data;
                out0_valid <= 1'b1;
            end else if (out0_valid && out0_ready) begin
                out0_valid <= 1'b0;
            end

            if (ch1_load) begin
                out1_data  <= in_data;
                out1_valid <= 1'b1;
            end else if (out1_valid && out1_ready) begin
                out1_valid <= 1'b0;
            end
        end
    end

    // Out-of-order words are still delivered; only the sequence state holds.
    always_comb begin
        state_next   = state;
        seq_err_next = 1'b0;
        frame_inc    = 1'b0;
        if (in_xfer) begin
            case (state)
                EXP0: begin
                    if (!in_sel) state_next   = EXP1;
                    else         seq_err_next = 1'b1;
                end
                EXP1: begin
                    if (in_sel) begin
                        state_next = EXP0;
                        frame_inc  = 1'b1;
                    end else begin
                        seq_err_next = 1'b1;
                    end
                end
                default: state_next = EXP0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EXP0;
            seq_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state   <= state_next;
            seq_err <= seq_err_next;
            if (frame_inc) frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_demux_1x2_tdm.sv
// Bench for demux_1x2_tdm: directed vector table, corner sequences, and
// randomized traffic compared against a channel-array reference model.
module tb_demux_1x2_tdm;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic             seq_err;
    logic [CNT_W-1:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    demux_1x2_tdm #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out1_data (out1_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .seq_err   (seq_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: one buffer per channel, the channel expected next,
    // and the frame count kept as a plain integer modulo 2^CNT_W.
    logic             m_valid [2];
    logic [WIDTH-1:0] m_data  [2];
    int               m_expect;
    int               m_frames;
    logic             m_err;

    typedef struct {
        logic             rst;
        logic             valid;
        logic             sel;
        logic [WIDTH-1:0] data;
        logic             r0;
        logic             r1;
        logic             rdy;
        logic             ov0;
        logic [WIDTH-1:0] od0;
        logic             ov1;
        logic [WIDTH-1:0] od1;
        logic             err;
        logic [CNT_W-1:0] fc;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        m_data[0]  = '0;   m_data[1]  = '0;
        m_expect   = 0;
        m_frames   = 0;
        m_err      = 1'b0;
    endtask

    // Drive one cycle, check in_ready before the edge and all outputs after it.
    task automatic drive(input logic r, input logic v, input logic s, input logic [WIDTH-1:0] d,
                         input logic r0, input logic r1, output logic rdy_seen);
        logic rdy_m;
        logic take;
        logic drain [2];
        rst = r; in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
        #1;
        rdy_seen = in_ready;
        rdy_m = !m_valid[s] || (s ? r1 : r0);
        chk("mdl_in_ready", {31'b0, in_ready}, {31'b0, rdy_m});
        if (r) begin
            model_reset();
        end else begin
            take     = v && rdy_m;
            drain[0] = m_valid[0] && r0;
            drain[1] = m_valid[1] && r1;
            for (int ch = 0; ch < 2; ch++) begin
                if (take && (int'(s) == ch)) begin
                    m_valid[ch] = 1'b1;
                    m_data[ch]  = d;
                end else if (drain[ch]) begin
                    m_valid[ch] = 1'b0;
                end
            end
            m_err = take && (int'(s) != m_expect);
            if (take && int'(s) == m_expect) begin
                if (m_expect == 1) m_frames = (m_frames + 1) % (1 << CNT_W);
                m_expect = 1 - m_expect;
            end
        end
        @(posedge clk);
        #1;
        chk("mdl_out0_valid", {31'b0, out0_valid}, {31'b0, m_valid[0]});
        chk("mdl_out0_data",  {24'b0, out0_data},  {24'b0, m_data[0]});
        chk("mdl_out1_valid", {31'b0, out1_valid}, {31'b0, m_valid[1]});
        chk("mdl_out1_data",  {24'b0, out1_data},  {24'b0, m_data[1]});
        chk("mdl_seq_err",    {31'b0, seq_err},    {31'b0, m_err});
        chk("mdl_frame_cnt",  {28'b0, frame_cnt},  m_frames[31:0]);
    endtask

    initial begin
        logic rdy;
        int   err_seen;

        // rst  v  s  data   r0 r1 | rdy ov0 od0    ov1 od1    err fc
        vecs[0]  = '{1'b0,1'b1,1'b0,8'h11, 1'b1,1'b1, 1'b1,1'b1,8'h11,1'b0,8'h00,1'b0,4'd0};
        vecs[1]  = '{1'b0,1'b1,1'b1,8'h22, 1'b1,1'b1, 1'b1,1'b0,8'h11,1'b1,8'h22,1'b0,4'd1};
        vecs[2]  = '{1'b0,1'b0,1'b0,8'h00, 1'b1,1'b1, 1'b1,1'b0,8'h11,1'b0,8'h22,1'b0,4'd1};
        vecs[3]  = '{1'b0,1'b1,1'b0,8'h11, 1'b0,1'b1, 1'b1,1'b1,8'h11,1'b0,8'h22,1'b0,4'd1};
        vecs[4]  = '{1'b0,1'b1,1'b0,8'h33, 1'b0,1'b1, 1'b0,1'b1,8'h11,1'b0,8'h22,1'b0,4'd1};
        vecs[5]  = '{1'b0,1'b1,1'b0,8'h33, 1'b1,1'b1, 1'b1,1'b1,8'h33,1'b0,8'h22,1'b1,4'd1};
        vecs[6]  = '{1'b0,1'b1,1'b1,8'h66, 1'b1,1'b1, 1'b1,1'b0,8'h33,1'b1,8'h66,1'b0,4'd2};
        vecs[7]  = '{1'b0,1'b1,1'b1,8'h44, 1'b1,1'b1, 1'b1,1'b0,8'h33,1'b1,8'h44,1'b1,4'd2};
        vecs[8]  = '{1'b0,1'b0,1'b0,8'h00, 1'b1,1'b1, 1'b1,1'b0,8'h33,1'b0,8'h44,1'b0,4'd2};
        vecs[9]  = '{1'b0,1'b1,1'b0,8'h77, 1'b0,1'b1, 1'b1,1'b1,8'h77,1'b0,8'h44,1'b0,4'd2};
        vecs[10] = '{1'b0,1'b1,1'b1,8'h55, 1'b0,1'b1, 1'b1,1'b1,8'h77,1'b1,8'h55,1'b0,4'd3};
        vecs[11] = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b1, 1'b0,1'b1,8'h77,1'b0,8'h55,1'b0,4'd3};
        vecs[12] = '{1'b0,1'b0,1'b0,8'h00, 1'b1,1'b1, 1'b1,1'b0,8'h77,1'b0,8'h55,1'b0,4'd3};
        vecs[13] = '{1'b0,1'b1,1'b0,8'h01, 1'b1,1'b1, 1'b1,1'b1,8'h01,1'b0,8'h55,1'b0,4'd3};
        vecs[14] = '{1'b1,1'b1,1'b1,8'h02, 1'b1,1'b1, 1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,4'd0};
        vecs[15] = '{1'b0,1'b1,1'b0,8'h03, 1'b1,1'b1, 1'b1,1'b1,8'h03,1'b0,8'h00,1'b0,4'd0};
        vecs[16] = '{1'b0,1'b1,1'b1,8'h04, 1'b1,1'b1, 1'b1,1'b0,8'h03,1'b1,8'h04,1'b0,4'd1};

        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        drive(1'b1, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, rdy);
        chk("rst_in_ready", {31'b0, rdy}, 32'd1);
        chk("rst_out0_valid", {31'b0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'b0, out1_valid}, 32'd0);
        chk("rst_frame_cnt", {28'b0, frame_cnt}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].sel, vecs[i].data,
                  vecs[i].r0, vecs[i].r1, rdy);
            chk($sformatf("vec%0d_in_ready", i), {31'b0, rdy}, {31'b0, vecs[i].rdy});
            chk($sformatf("vec%0d_out0_valid", i), {31'b0, out0_valid}, {31'b0, vecs[i].ov0});
            chk($sformatf("vec%0d_out0_data", i), {24'b0, out0_data}, {24'b0, vecs[i].od0});
            chk($sformatf("vec%0d_out1_valid", i), {31'b0, out1_valid}, {31'b0, vecs[i].ov1});
            chk($sformatf("vec%0d_out1_data", i), {24'b0, out1_data}, {24'b0, vecs[i].od1});
            chk($sformatf("vec%0d_seq_err", i), {31'b0, seq_err}, {31'b0, vecs[i].err});
            chk($sformatf("vec%0d_frame_cnt", i), {28'b0, frame_cnt}, {28'b0, vecs[i].fc});
        end

        // Counter wrap: 16 clean frames on a 4-bit counter.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, rdy);
        err_seen = 0;
        for (int f = 1; f <= 16; f++) begin
            drive(1'b0, 1'b1, 1'b0, f[7:0], 1'b1, 1'b1, rdy);
            if (seq_err) err_seen++;
            drive(1'b0, 1'b1, 1'b1, 8'h80 | f[7:0], 1'b1, 1'b1, rdy);
            if (seq_err) err_seen++;
            if (f == 15) chk("wrap_cnt_15", {28'b0, frame_cnt}, 32'd15);
            if (f == 16) chk("wrap_cnt_0", {28'b0, frame_cnt}, 32'd0);
        end
        chk("wrap_no_err", err_seen, 0);

        // Randomized traffic with occasional reset.
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, rdy);
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 4) < 2),
                  8'($urandom),
                  ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) < 7),
                  rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1x2_tdm.md
DEMUX_1X2_TDM -- requirements
Module: demux_1x2_tdm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each word.
REQ-002 SHALL have parameter CNT_W, default 16, width of the frame counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_sel  input  1  destination channel of the word (0 or 1).
REQ-007 SHALL have port in_data  input  WIDTH  upstream word.
REQ-008 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-009 SHALL have port out0_data  output  WIDTH  channel-0 word.
REQ-010 SHALL have port out0_valid  output  1  channel-0 word present.
REQ-011 SHALL have port out0_ready  input  1  channel-0 consumer accepts.
REQ-012 SHALL have ports out1_data, out1_valid and out1_ready, identical in direction, width and meaning to the channel-0 ports, for channel 1.
REQ-013 SHALL have port seq_err  output  1  one-cycle pulse on an out-of-order word.
REQ-014 SHALL have port frame_cnt  output  CNT_W  count of completed ch0->ch1 frames.

Function
REQ-015 SHALL hold one registered output buffer per channel (data + valid); no combinational path from in_data to outN_data.
REQ-016 SHALL transfer on input when in_valid && in_ready; SHALL transfer on output N when outN_valid && outN_ready.
REQ-017 SHALL drive in_ready = !outS_valid || outS_ready, where S = in_sel; in_ready depends only on the selected channel.
REQ-018 On input transfer SHALL load in_data into buffer S and set outS_valid next cycle; latency 1 cycle.
REQ-019 On simultaneous input transfer and output transfer of the same channel, SHALL load the new word and keep outS_valid = 1.
REQ-020 On output transfer with no reload, SHALL clear outN_valid next cycle; outN_data holds its last value.
REQ-021 SHALL keep outN_data stable while outN_valid = 1 and outN_ready = 0.
REQ-022 Input transfers to one channel SHALL NOT affect the other channel's buffer.
REQ-023 SHALL run a 2-state sequence FSM: EXP0 (expect sel = 0), EXP1 (expect sel = 1); states change only on input transfer.
REQ-024 In EXP0: sel = 0 -> EXP1; sel = 1 -> stay EXP0, pulse seq_err, word still delivered to channel 1.
REQ-025 In EXP1: sel = 1 -> EXP0 and frame_cnt += 1; sel = 0 -> stay EXP1, pulse seq_err, word delivered to channel 0.
REQ-026 seq_err SHALL be registered, high exactly the cycle after the offending transfer, low otherwise.
REQ-027 frame_cnt SHALL wrap from 2^CNT_W-1 to 0 without error indication.
REQ-028 in_valid = 0 or in_ready = 0 SHALL leave FSM, counter and buffers unchanged (except output drain).

Reset
REQ-029 On rst = 1 at a clock edge SHALL set out0_valid = out1_valid = 0, out0_data = out1_data = 0, seq_err = 0, frame_cnt = 0, FSM = EXP0.
REQ-030 rst SHALL take priority over any simultaneous transfer; words in flight are discarded.
REQ-031 While rst = 1, in_ready SHALL evaluate per REQ-017 against the cleared buffers (i.e. 1) but no transfer takes effect.

Verification
REQ-032 Reset, then words 0x11 (sel 0), 0x22 (sel 1), both readies 1 -> out0 = 0x11 valid one cycle, then out1 = 0x22, frame_cnt = 1, seq_err never high.
REQ-033 out0_ready = 0, send 0x11 then 0x33 on sel 0 -> second word stalls with in_ready = 0, out0_data stays 0x11; raise out0_ready -> 0x33 accepted same cycle, out0_valid stays 1.
REQ-034 From EXP0 send sel 1 word 0x44 -> seq_err pulses one cycle, out1 = 0x44, frame_cnt unchanged, FSM still EXP0.
REQ-035 CNT_W = 4, 16 correct frames -> frame_cnt reads 15 then 0, no error.
REQ-036 Assert rst the cycle a sel 1 word completes a frame -> frame_cnt = 0, both valids 0, next sel 0 word accepted as EXP0.
REQ-037 out0_ready = 0 with channel 0 full, send sel 1 word 0x55 -> in_ready = 1, out1 = 0x55, channel 0 unchanged.
